// File: rtl/fetch_controller_pkg.sv
// Types and constants shared by the fetch controller and its sub-blocks.
package fetch_controller_pkg;

    localparam int ROM_ADDR_WIDTH       = 32;
    localparam int DRAIN_CYCLES_DEFAULT = 3;
    localparam int DRAIN_CNT_WIDTH      = 4;

    typedef logic [ROM_ADDR_WIDTH-1:0] RomAddress;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } FetchState;

endpackage

// File: rtl/saturating_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; usable for any perf event.
module saturating_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;

    // Count register: clear has priority, increment only below saturation
    always_ff @(posedge clk) begin
        if (clear) begin
            count_r <= {WIDTH{1'b0}};
        end else if (inc && (count_r != {WIDTH{1'b1}})) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/fetch_controller.sv
// PC redirect arbitration, front-end stall/flush generation and EBREAK halt with drain.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter int PERF_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_branch_taken,
    input  RomAddress             ex_branch_target,
    input  logic                  id_jump,
    input  RomAddress             id_jump_target,
    input  logic                  load_use_hazard,
    input  logic                  imem_ready,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic                  pc_stall,
    output logic                  pc_should_branch,
    output RomAddress             pc_branch_target,
    output logic                  stall_if_id,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  halted,
    output logic [PERF_WIDTH-1:0] redirect_count
);

    localparam logic [DRAIN_CNT_WIDTH-1:0] DRAIN_LOAD = DRAIN_CNT_WIDTH'(DRAIN_CYCLES - 1);
    localparam logic [DRAIN_CNT_WIDTH-1:0] CNT_ZERO   = {DRAIN_CNT_WIDTH{1'b0}};
    localparam logic [DRAIN_CNT_WIDTH-1:0] CNT_ONE    = {{(DRAIN_CNT_WIDTH-1){1'b0}}, 1'b1};

    FetchState                  state_r;
    FetchState                  state_next_s;
    logic [DRAIN_CNT_WIDTH-1:0] drain_cnt_r;
    logic [DRAIN_CNT_WIDTH-1:0] drain_cnt_next_s;
    logic                       halted_r;

    // State, drain counter and halted flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= RUN;
            drain_cnt_r <= CNT_ZERO;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            drain_cnt_r <= drain_cnt_next_s;
            halted_r    <= (state_next_s == HALTED);
        end
    end

    // Next state and zero-latency front-end controls
    always_comb begin
        state_next_s     = state_r;
        drain_cnt_next_s = drain_cnt_r;
        pc_stall         = 1'b0;
        pc_should_branch = 1'b0;
        pc_branch_target = {ROM_ADDR_WIDTH{1'b0}};
        stall_if_id      = 1'b0;
        flush_if_id      = 1'b0;
        flush_id_ex      = 1'b0;

        case (state_r)
            RUN: begin
                // The EX branch is older, so a same-cycle ID jump is wrong-path
                if (ex_branch_taken) begin
                    pc_should_branch = 1'b1;
                    pc_branch_target = ex_branch_target;
                    flush_if_id      = 1'b1;
                    flush_id_ex      = 1'b1;
                end else if (id_jump) begin
                    pc_should_branch = 1'b1;
                    pc_branch_target = id_jump_target;
                    flush_if_id      = 1'b1;
                end else if (load_use_hazard) begin
                    pc_stall    = 1'b1;
                    stall_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (!imem_ready) begin
                    pc_stall    = 1'b1;
                    flush_if_id = 1'b1;
                end else if (halt_req) begin
                    pc_stall         = 1'b1;
                    flush_if_id      = 1'b1;
                    state_next_s     = DRAIN;
                    drain_cnt_next_s = DRAIN_LOAD;
                end else begin
                    state_next_s = RUN;
                end
            end

            DRAIN: begin
                pc_stall    = 1'b1;
                flush_if_id = 1'b1;
                // A taken older branch means the EBREAK itself was wrong-path
                if (ex_branch_taken) begin
                    pc_should_branch = 1'b1;
                    pc_branch_target = ex_branch_target;
                    flush_id_ex      = 1'b1;
                    state_next_s     = RUN;
                    drain_cnt_next_s = CNT_ZERO;
                end else if (drain_cnt_r == CNT_ZERO) begin
                    state_next_s = HALTED;
                end else begin
                    drain_cnt_next_s = drain_cnt_r - CNT_ONE;
                end
            end

            HALTED: begin
                pc_stall    = 1'b1;
                stall_if_id = 1'b1;
                if (resume) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = HALTED;
                end
            end

            default: begin
                state_next_s     = RUN;
                drain_cnt_next_s = CNT_ZERO;
            end
        endcase
    end

    assign halted = halted_r;

    saturating_counter #(
        .WIDTH (PERF_WIDTH)
    ) u_redirect_counter (
        .clk   (clk),
        .clear (reset),
        .inc   (pc_should_branch),
        .count (redirect_count)
    );

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized scoreboard bench for fetch_controller with a behavioural PC alongside.
module tb_fetch_controller;
    import fetch_controller_pkg::*;

    localparam int DRAIN = 3;
    localparam int PW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ex_branch_taken;
    RomAddress     ex_branch_target;
    logic          id_jump;
    RomAddress     id_jump_target;
    logic          load_use_hazard;
    logic          imem_ready;
    logic          halt_req;
    logic          resume;
    logic          pc_stall;
    logic          pc_should_branch;
    RomAddress     pc_branch_target;
    logic          stall_if_id;
    logic          flush_if_id;
    logic          flush_id_ex;
    logic          halted;
    logic [PW-1:0] redirect_count;

    always #5 clk = ~clk;

    fetch_controller #(
        .DRAIN_CYCLES (DRAIN),
        .PERF_WIDTH   (PW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .id_jump          (id_jump),
        .id_jump_target   (id_jump_target),
        .load_use_hazard  (load_use_hazard),
        .imem_ready       (imem_ready),
        .halt_req         (halt_req),
        .resume           (resume),
        .pc_stall         (pc_stall),
        .pc_should_branch (pc_should_branch),
        .pc_branch_target (pc_branch_target),
        .stall_if_id      (stall_if_id),
        .flush_if_id      (flush_if_id),
        .flush_id_ex      (flush_id_ex),
        .halted           (halted),
        .redirect_count   (redirect_count)
    );

    typedef struct packed {
        logic          stall;
        logic          sb;
        RomAddress     tgt;
        logic          sif;
        logic          fif;
        logic          fie;
        logic          halted;
        logic [PW-1:0] count;
    } exp_t;

    typedef enum {M_RUN, M_DRAIN, M_HALTED} mode_t;

    exp_t      exp_q[$];
    int        vectors     = 0;
    int        miscompares = 0;
    mode_t     m_mode      = M_RUN;
    int        m_left      = 0;
    int        m_count     = 0;
    bit        m_known     = 1'b0;
    RomAddress tb_pc;

    // Behavioural program_counter driven by the controller outputs
    always @(posedge clk) begin
        if (reset) tb_pc <= '0;
        else if (pc_should_branch) tb_pc <= pc_branch_target;
        else if (!pc_stall) tb_pc <= tb_pc + 32'd4;
    end

    task automatic step(input logic ex, input RomAddress ext, input logic idj, input RomAddress idt,
                        input logic lu, input logic imr, input logic hr, input logic res, input logic rst);
        exp_t e;
        @(negedge clk);
        reset = rst; ex_branch_taken = ex; ex_branch_target = ext; id_jump = idj;
        id_jump_target = idt; load_use_hazard = lu; imem_ready = imr; halt_req = hr; resume = res;
        if (!rst && m_known) begin
            e = '0;
            e.halted = (m_mode == M_HALTED);
            e.count  = PW'(m_count);
            case (m_mode)
                M_RUN: begin
                    if (ex) begin
                        e.sb = 1'b1; e.tgt = ext; e.fif = 1'b1; e.fie = 1'b1;
                    end else if (idj) begin
                        e.sb = 1'b1; e.tgt = idt; e.fif = 1'b1;
                    end else if (lu) begin
                        e.stall = 1'b1; e.sif = 1'b1; e.fie = 1'b1;
                    end else if (!imr) begin
                        e.stall = 1'b1; e.fif = 1'b1;
                    end else if (hr) begin
                        e.stall = 1'b1; e.fif = 1'b1;
                        m_mode = M_DRAIN; m_left = DRAIN;
                    end
                end
                M_DRAIN: begin
                    e.stall = 1'b1; e.fif = 1'b1;
                    if (ex) begin
                        e.sb = 1'b1; e.tgt = ext; e.fie = 1'b1;
                        m_mode = M_RUN;
                    end else begin
                        m_left--;
                        if (m_left == 0) m_mode = M_HALTED;
                    end
                end
                default: begin
                    e.stall = 1'b1; e.sif = 1'b1;
                    if (res) m_mode = M_RUN;
                end
            endcase
            if (e.sb && m_count < (1 << PW) - 1) m_count++;
            exp_q.push_back(e);
        end
        if (rst) begin
            m_mode = M_RUN; m_left = 0; m_count = 0; m_known = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_pc(input string name, input RomAddress want);
        vectors++;
        if (tb_pc !== want) begin
            miscompares++;
            $display("FAIL %s: pc got %h want %h", name, tb_pc, want);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares away from the clock edge
    initial begin : monitor
        exp_t e;
        bit   bad;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                bad = (pc_should_branch !== e.sb) || (pc_branch_target !== e.tgt) ||
                      (stall_if_id !== e.sif) || (flush_if_id !== e.fif) ||
                      (flush_id_ex !== e.fie) || (halted !== e.halted) ||
                      (redirect_count !== e.count) || (!e.sb && (pc_stall !== e.stall));
                if (bad) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got stall=%b sb=%b tgt=%h sif=%b fif=%b fie=%b halted=%b cnt=%0d want stall=%b sb=%b tgt=%h sif=%b fif=%b fie=%b halted=%b cnt=%0d",
                             $time, pc_stall, pc_should_branch, pc_branch_target, stall_if_id, flush_if_id,
                             flush_id_ex, halted, redirect_count, e.stall, e.sb, e.tgt, e.sif, e.fif,
                             e.fie, e.halted, e.count);
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; ex_branch_taken = 1'b0; ex_branch_target = '0; id_jump = 1'b0;
        id_jump_target = '0; load_use_hazard = 1'b0; imem_ready = 1'b1; halt_req = 1'b0; resume = 1'b0;

        repeat (2) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_pc("reset_pc", 32'h0);
        repeat (4) idle();
        check_pc("sequential", 32'h10);

        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_pc("load_use_hold", 32'h10);
        idle();
        check_pc("load_use_resume", 32'h14);

        step(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_pc("ex_over_id", 32'h40);

        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_pc("jump_during_imem_stall", 32'h20);

        step(1'b0, '0, 1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_pc("jump_to_c", 32'hC);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) idle();
        idle();
        check_pc("halted_frozen", 32'hC);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        check_pc("after_resume", 32'h10);

        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        step(1'b1, 32'h100, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_pc("drain_cancel", 32'h100);
        repeat (5) idle();
        check_pc("run_after_cancel", 32'h114);

        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) idle();
        step(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_pc("branch_ignored_halted", 32'h114);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_pc("reset_in_halted", 32'h0);
        idle();
        check_pc("run_after_reset", 32'h4);

        repeat (3000) begin
            step(($urandom_range(0, 7) == 0), RomAddress'($urandom() & 32'hFFFF_FFFC),
                 ($urandom_range(0, 7) == 0), RomAddress'($urandom() & 32'hFFFF_FFFC),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 299) == 0));
        end

        repeat (2) @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the program counter and the front of the pipeline: arbitrates PC redirect sources, generates PC stall and IF/ID and ID/EX flush/stall controls, and handles halt (EBREAK) with pipeline drain.
- Sits between the hazard sources (ID jump decode, EX branch resolution, load-use detector, instruction ROM ready) and the program_counter block.
- Drives program_counter's stall, should_branch and branch_target.

Parameters:
- DRAIN_CYCLES, 3, cycles PC stays frozen after a halt request before halted asserts (lets older instructions retire); legal range 1..15
- PERF_WIDTH, 16, width of the saturating redirect performance counter

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high; sampled on posedge clk
- ex_branch_taken  input  1  branch/JALR in EX resolved taken
- ex_branch_target  input  RomAddress  target for ex_branch_taken
- id_jump  input  1  JAL decoded in ID
- id_jump_target  input  RomAddress  target for id_jump
- load_use_hazard  input  1  ID instruction needs a load result not yet available
- imem_ready  input  1  instruction ROM has valid data for current PC
- halt_req  input  1  EBREAK decoded in ID
- resume  input  1  external debug resume
- pc_stall  output  1  to program_counter stall
- pc_should_branch  output  1  to program_counter should_branch
- pc_branch_target  output  RomAddress  to program_counter branch_target
- stall_if_id  output  1  hold IF/ID register
- flush_if_id  output  1  zero (bubble) IF/ID register
- flush_id_ex  output  1  insert bubble into ID/EX
- halted  output  1  core halted
- redirect_count  output  PERF_WIDTH  number of accepted redirects, saturating

Behaviour:
- State machine, state register: RUN, DRAIN, HALTED. Reset → RUN, drain counter 0, redirect_count 0. Reset wins over every other input in the same cycle, including mid-DRAIN and HALTED.
- All outputs except halted and redirect_count are combinational from state and current inputs; zero-latency so program_counter registers the decision on the same edge.
- Redirect priority: ex_branch_taken > id_jump. The EX branch is older, so the ID jump is on the wrong path and is discarded.
- RUN:
  - ex_branch_taken → pc_should_branch=1, target=ex_branch_target, flush_if_id=1, flush_id_ex=1.
  - Else id_jump → pc_should_branch=1, target=id_jump_target, flush_if_id=1, flush_id_ex=0.
  - Else load_use_hazard → pc_stall=1, stall_if_id=1, flush_id_ex=1.
  - Else !imem_ready → pc_stall=1, flush_if_id=1; stall_if_id=0 so the bubble enters.
  - Else halt_req → pc_stall=1, flush_if_id=1, next state DRAIN, counter loads DRAIN_CYCLES-1.
  - A redirect coinciding with load_use_hazard or !imem_ready: redirect wins, since program_counter follows the branch even when stalling. pc_stall may still be 1; should_branch overrides it in the PC.
  - Idle values: pc_should_branch=0, pc_branch_target=0.
- DRAIN:
  - pc_stall=1 and flush_if_id=1 every cycle; counter decrements; at counter==0 → HALTED.
  - ex_branch_taken during DRAIN means the EBREAK was on the wrong path: cancel halt, redirect as in RUN, next state RUN.
  - id_jump is ignored in DRAIN.
- HALTED:
  - halted=1 (registered: asserted the cycle after the transition), pc_stall=1, stall_if_id=1, no flushes.
  - resume → RUN next cycle; halted deasserts the same edge; PC continues from the held value.
  - Branch inputs are ignored while HALTED.
- redirect_count: +1 on each cycle pc_should_branch=1; holds at all-ones (no wrap).

Decomposition:
- Shared types header: RomAddress (existing), the FetchState enum {RUN, DRAIN, HALTED}, DRAIN_CYCLES default.
- One natural sub-module: saturating_counter (WIDTH param, inc, clear), reusable for other perf counters.
- FSM and priority logic stay in fetch_controller.

Test Plan:
- Reset held 2 cycles then released, with program_counter instantiated → PC 0,4,8,…; redirect_count=0; halted=0.
- ex_branch_taken=1, target 0x40, same cycle as id_jump to 0x80 → next PC 0x40, flush_if_id=flush_id_ex=1, redirect_count=1.
- load_use_hazard 1 cycle at PC=0x10 → PC holds 0x10 one cycle, flush_id_ex=1, then 0x14.
- imem_ready=0 for 3 cycles, id_jump to 0x20 in the 2nd cycle → PC goes to 0x20 despite stall; flush_if_id high all 3 cycles.
- halt_req at PC=0xC, DRAIN_CYCLES=3 → PC frozen, halted=1 after 4 edges; resume → PC advances to 0x10 next cycle.
- halt_req, then ex_branch_taken to 0x100 during DRAIN → halted never asserts, PC=0x100, state RUN; reset asserted in HALTED → state RUN, PC=0, count=0.
